// File: rtl/sobel_pkg.sv
// Shared types and constants for the BMP frame streamer and its byte packer.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } state_t;

  localparam logic [1:0] PH_B = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_R = 2'd2;

  localparam int BYTES_PER_PIXEL = 3;

endpackage

// File: rtl/bgr_pixel_packer.sv
// Collects B, G, R bytes in stream order and presents them as one RGB pixel
// with a single-cycle valid pulse.
module bgr_pixel_packer
  import sobel_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic       clear_i,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       pixel_valid_o
);

  logic [1:0] r_phase;
  logic [7:0] r_blue_hold;
  logic [7:0] r_green_hold;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic       r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= PH_B;
      r_blue_hold  <= '0;
      r_green_hold <= '0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (clear_i) begin
        r_phase <= PH_B;
      end else if (byte_valid_i) begin
        case (r_phase)
          PH_B: begin
            r_blue_hold <= byte_i;
            r_phase     <= PH_G;
          end
          PH_G: begin
            r_green_hold <= byte_i;
            r_phase      <= PH_R;
          end
          default: begin
            // All three components update together so the sink never sees a mixed pixel.
            r_red   <= byte_i;
            r_green <= r_green_hold;
            r_blue  <= r_blue_hold;
            r_valid <= 1'b1;
            r_phase <= PH_B;
          end
        endcase
      end
    end
  end

  assign red_o         = r_red;
  assign green_o       = r_green;
  assign blue_o        = r_blue;
  assign pixel_valid_o = r_valid;

endmodule

// File: rtl/bmp_frame_streamer.sv
// Streams one bottom-up 24-bit BMP frame from byte-wide memory as
// valid-qualified RGB pixels for the sobel camera interface.
module bmp_frame_streamer
  import sobel_pkg::*;
#(
  parameter int ROWS   = 400,
  parameter int COLS   = 400,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        cam_red_o,
  output logic [7:0]        cam_green_o,
  output logic [7:0]        cam_blue_o,
  output logic              cam_done_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int N     = ROWS * COLS;
  localparam int TOTAL = N * BYTES_PER_PIXEL;
  localparam int BW    = $clog2(TOTAL);
  localparam int PW    = $clog2(N);

  localparam logic [BW-1:0] LAST_BYTE  = BW'(TOTAL - 1);
  localparam logic [PW-1:0] LAST_PIXEL = PW'(N - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [BW-1:0]     r_byte_cnt;
  logic [PW-1:0]     r_pix_cnt;
  logic              r_rd_d1;
  logic              w_accept;
  logic              w_last_byte;
  logic              w_pixel_valid;

  assign w_accept    = (r_state == IDLE) && start_i;
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next_state = READ;
      READ:    if (w_last_byte) w_next_state = DRAIN;
      DRAIN:   w_next_state = FINISH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The address stops on the last issued byte so it holds while reads are idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_byte_cnt <= '0;
    end else if (w_accept) begin
      r_addr     <= base_addr_i;
      r_byte_cnt <= '0;
    end else if (r_state == READ && !w_last_byte) begin
      r_addr     <= r_addr + ADDR_W'(1);
      r_byte_cnt <= r_byte_cnt + BW'(1);
    end
  end

  // Read data returns one cycle after the request, so the valid flag is the delayed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_d1 <= 1'b0;
    else     r_rd_d1 <= mem_rd_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt <= '0;
    end else if (w_accept) begin
      r_pix_cnt <= '0;
    end else if (w_pixel_valid) begin
      r_pix_cnt <= (r_pix_cnt == LAST_PIXEL) ? '0 : r_pix_cnt + PW'(1);
    end
  end

  bgr_pixel_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (mem_data_i),
    .byte_valid_i (r_rd_d1),
    .clear_i      (w_accept),
    .red_o        (cam_red_o),
    .green_o      (cam_green_o),
    .blue_o       (cam_blue_o),
    .pixel_valid_o(w_pixel_valid)
  );

  assign mem_addr_o   = r_addr;
  assign mem_rd_o     = (r_state == READ);
  assign cam_done_o   = w_pixel_valid;
  assign busy_o       = (r_state != IDLE);
  assign frame_done_o = w_pixel_valid && (r_pix_cnt == LAST_PIXEL);

endmodule
